spi_core: RTL and testbench

- Serial shift engine of the SPI master. Sits between the register/FIFO front end (CTRL fields, TX/RX data words) and the SPI pins.
- Takes one TX word per transfer and generates SCK, NSS and MOSI according to CPOL/CPHA/LSB/DIV/DTB/ASS/NSS.
- Samples MISO and returns one RX word per transfer, plus a done pulse used as the interrupt source.

---
 rtl/spi_core_pkg.sv | 30 +++
 rtl/spi_clkgen.sv | 64 ++++++
 rtl/spi_core.sv | 184 ++++++++++++++++++
 tb/tb_spi_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_core_pkg.sv
// Shared definitions for the SPI master shift engine.
//   - spi_state_e : transfer FSM states
//   - DTB_*       : CTRL.DTB encodings
//   - dtb_to_bits : maps a DTB code to the number of bits per transfer
package spi_core_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLead,
        StXfer,
        StTrail
    } spi_state_e;

    localparam logic [1:0] DTB_8  = 2'b00;
    localparam logic [1:0] DTB_16 = 2'b01;
    localparam logic [1:0] DTB_24 = 2'b10;
    localparam logic [1:0] DTB_32 = 2'b11;

    function automatic logic [5:0] dtb_to_bits(input logic [1:0] dtb);
        logic [5:0] bits;
        case (dtb)
            DTB_8:   bits = 6'd8;
            DTB_16:  bits = 6'd16;
            DTB_24:  bits = 6'd24;
            default: bits = 6'd32;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period divider and SCK edge counter for spi_core.
// Ports:
//   i_clk, i_rst      : system clock, asynchronous active-high reset
//   i_clear           : reload divider from i_div and zero the edge count (start/abort)
//   i_run             : transfer active; divider counts down
//   i_edge_en         : ticks in this phase produce SCK edges (LEAD/XFER)
//   i_div             : half period minus one, captured on i_clear
//   i_nbits           : bits per transfer (N); 2N edges are generated
//   o_tick            : end of a half period
//   o_lead_edge       : odd-numbered SCK edge this cycle
//   o_trail_edge      : even-numbered SCK edge this cycle
//   o_last_edge       : this cycle's edge is edge 2N
module spi_clkgen
    import spi_core_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_run,
    input  logic       i_edge_en,
    input  logic [7:0] i_div,
    input  logic [5:0] i_nbits,
    output logic       o_tick,
    output logic       o_lead_edge,
    output logic       o_trail_edge,
    output logic       o_last_edge
);

    logic [7:0] r_div;
    logic [7:0] r_cnt;
    logic [6:0] r_edge;   // edges already produced
    logic       w_edge;
    logic [6:0] w_last_idx;

    assign o_tick       = i_run & (r_cnt == 8'd0);
    assign w_edge       = o_tick & i_edge_en;
    // Edge number is r_edge+1, so an even r_edge means an odd (leading) edge.
    assign o_lead_edge  = w_edge & ~r_edge[0];
    assign o_trail_edge = w_edge & r_edge[0];
    assign w_last_idx   = {i_nbits, 1'b0} - 7'd1;
    assign o_last_edge  = w_edge & (r_edge == w_last_idx);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div  <= 8'd0;
            r_cnt  <= 8'd0;
            r_edge <= 7'd0;
        end else if (i_clear) begin
            r_div  <= i_div;
            r_cnt  <= i_div;
            r_edge <= 7'd0;
        end else if (i_run) begin
            if (r_cnt == 8'd0) begin
                r_cnt <= r_div;
                if (i_edge_en) begin
                    r_edge <= r_edge + 7'd1;
                end
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_core.sv
// Serial shift engine of the SPI master. Accepts one TX word per transfer,
// drives SCK/NSS/MOSI, samples MISO and returns one RX word plus a done pulse.
// Ports:
//   clk_i, rst_i                 : system clock, asynchronous active-high reset
//   en_i, cpol_i, cpha_i, lsb_i  : CTRL enable, clock polarity/phase, LSB-first
//   ass_i, nss_i                 : automatic slave select, slave index
//   div_i                        : half period H = div_i+1 clocks
//   dtb_i                        : bits per transfer (8/16/24/32)
//   tx_valid_i/tx_ready_o/tx_data_i : TX word handshake
//   rx_valid_o/rx_ready_i/rx_data_o : RX word handshake (held until consumed)
//   busy_o, done_o               : transfer in progress, completion pulse
//   spi_sck_o, spi_nss_o, spi_mosi_o, spi_miso_i : SPI pins
module spi_core
    import spi_core_pkg::*;
#(
    parameter int unsigned SPI_NSS_NUM = 1,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   cpol_i,
    input  logic                   cpha_i,
    input  logic                   lsb_i,
    input  logic                   ass_i,
    input  logic [2:0]             nss_i,
    input  logic [7:0]             div_i,
    input  logic [1:0]             dtb_i,
    input  logic                   tx_valid_i,
    input  logic [DATA_WIDTH-1:0]  tx_data_i,
    output logic                   tx_ready_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic [DATA_WIDTH-1:0]  rx_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   spi_sck_o,
    output logic [SPI_NSS_NUM-1:0] spi_nss_o,
    output logic                   spi_mosi_o,
    input  logic                   spi_miso_i
);

    spi_state_e             r_state;
    logic                   r_cpol;
    logic                   r_cpha;
    logic                   r_lsb;
    logic [5:0]             r_nbits;
    logic [DATA_WIDTH-1:0]  r_tx;
    logic [DATA_WIDTH-1:0]  r_rx_sh;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_done;
    logic                   r_sck;
    logic [SPI_NSS_NUM-1:0] r_nss;

    logic                   w_start;
    logic                   w_abort;
    logic                   w_tick;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_last;
    logic                   w_edge;
    logic                   w_sample;
    logic                   w_shift;
    logic [4:0]             w_msb_idx;
    logic [DATA_WIDTH-1:0]  w_miso_ins;

    // Low on the line at idx when low is set; an out-of-range idx matches nothing.
    function automatic logic [SPI_NSS_NUM-1:0] nss_mask(input logic low, input logic [2:0] idx);
        logic [SPI_NSS_NUM-1:0] m;
        for (int unsigned i = 0; i < SPI_NSS_NUM; i++) begin
            m[i] = ~(low && (32'(idx) == i));
        end
        return m;
    endfunction

    assign w_start = (r_state == StIdle) & en_i & tx_valid_i & ~r_rx_valid;
    assign w_abort = (r_state != StIdle) & ~en_i;

    spi_clkgen u_clkgen (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_clear      (w_start | w_abort),
        .i_run        (r_state != StIdle),
        .i_edge_en    ((r_state == StLead) | (r_state == StXfer)),
        .i_div        (div_i),
        .i_nbits      (r_nbits),
        .o_tick       (w_tick),
        .o_lead_edge  (w_lead),
        .o_trail_edge (w_trail),
        .o_last_edge  (w_last)
    );

    assign w_edge     = w_lead | w_trail;
    assign w_msb_idx  = 5'(r_nbits - 6'd1);
    assign w_miso_ins = DATA_WIDTH'(spi_miso_i) << w_msb_idx;
    // CPHA=1: the first leading edge only presents the bit already on MOSI.
    // CPHA=0: the final trailing edge must not shift past the last bit.
    assign w_sample   = r_cpha ? w_trail : w_lead;
    assign w_shift    = r_cpha ? (w_lead & (r_state != StLead)) : (w_trail & ~w_last);

    assign tx_ready_o = w_start;
    assign busy_o     = (r_state != StIdle);
    assign done_o     = r_done;
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign spi_sck_o  = r_sck;
    assign spi_nss_o  = r_nss;
    assign spi_mosi_o = (r_state != StIdle) & (r_lsb ? r_tx[0] : r_tx[w_msb_idx]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_nbits    <= 6'd8;
            r_tx       <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= 1'b0;
            r_nss      <= '1;
        end else begin
            r_done <= 1'b0;
            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
            if (w_abort) begin
                r_state <= StIdle;
                r_sck   <= r_cpol;
                r_nss   <= '1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_sck <= cpol_i;
                        if (w_start) begin
                            r_state <= StLead;
                            r_cpol  <= cpol_i;
                            r_cpha  <= cpha_i;
                            r_lsb   <= lsb_i;
                            r_nbits <= dtb_to_bits(dtb_i);
                            r_tx    <= tx_data_i;
                            r_rx_sh <= '0;
                            r_nss   <= nss_mask(1'b1, nss_i);
                        end else begin
                            r_nss <= nss_mask(en_i & ~ass_i, nss_i);
                        end
                    end
                    StLead, StXfer: begin
                        if (w_edge) begin
                            r_sck <= ~r_sck;
                        end
                        if (w_sample) begin
                            r_rx_sh <= r_lsb ? ((r_rx_sh >> 1) | w_miso_ins)
                                             : {r_rx_sh[DATA_WIDTH-2:0], spi_miso_i};
                        end
                        if (w_shift) begin
                            r_tx <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
                        end
                        if (r_state == StLead && w_edge) begin
                            r_state <= StXfer;
                        end
                        if (w_last) begin
                            r_state <= StTrail;
                        end
                    end
                    StTrail: begin
                        if (w_tick) begin
                            r_state    <= StIdle;
                            r_done     <= 1'b1;
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_rx_sh;
                            r_nss      <= nss_mask(en_i & ~ass_i, nss_i);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_core.sv
module tb_spi_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, cpol, cpha, lsb, ass;
    logic [2:0]  nss;
    logic [7:0]  div;
    logic [1:0]  dtb;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic        busy, done;
    logic        sck, mosi, miso;
    logic [3:0]  nss_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] rx;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    int   edge_q[$];
    logic mosi_q[$];
    logic prev_sck = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso = mosi;  // loopback

    spi_core #(.SPI_NSS_NUM(4), .DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .lsb_i      (lsb),
        .ass_i      (ass),
        .nss_i      (nss),
        .div_i      (div),
        .dtb_i      (dtb),
        .tx_valid_i (tx_valid),
        .tx_data_i  (tx_data),
        .tx_ready_o (tx_ready),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .rx_data_o  (rx_data),
        .busy_o     (busy),
        .done_o     (done),
        .spi_sck_o  (sck),
        .spi_nss_o  (nss_o),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso)
    );

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected transfer.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check(1'b0, "unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(rx_data == e.rx, "rx_data", rx_data, e.rx);
                check(cyc == e.due, "done_cycle", cyc, e.due);
                check(rx_valid == 1'b1, "rx_valid_at_done", rx_valid, 1);
            end
        end
    end

    // SCK edge watcher: cycle of every edge, MOSI at every leading edge.
    always @(negedge clk) begin
        if (!rst && sck != prev_sck) begin
            edge_q.push_back(cyc);
            if (sck != cpol) mosi_q.push_back(mosi);
        end
        prev_sck <= sck;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one TX word; returns the handshake cycle T (or -1 on timeout).
    task automatic start_xfer(input logic [31:0] tx, input logic [31:0] exp_rx,
                              input int lat, input bit expect_done, output int t);
        t = -1;
        tx_data  = tx;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && t < 0; i++) begin
            @(negedge clk);
            if (tx_ready) t = cyc;
        end
        if (t < 0) begin
            check(1'b0, "tx_ready_timeout", 0, 1);
            tx_valid = 1'b0;
        end else begin
            if (expect_done) sb_q.push_back('{rx: exp_rx, due: t + lat});
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check(1'b0, "done_timeout", 0, 1);
    endtask

    initial begin
        int t, t2, r, rdy_seen, dc;
        logic [7:0] mb;

        rst = 1'b1; en = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; ass = 1'b1;
        nss = 3'd0; div = 8'd0; dtb = 2'b00; tx_valid = 1'b0; tx_data = 32'h0;
        rx_ready = 1'b1;
        step(3);

        // Reset state
        check({sck, mosi, tx_ready, rx_valid, busy, done} == 6'b0, "reset_ctl",
              {sck, mosi, tx_ready, rx_valid, busy, done}, 0);
        check(nss_o == 4'hF, "reset_nss", nss_o, 4'hF);
        check(rx_data == 32'h0, "reset_rx_data", rx_data, 0);
        rst = 1'b0;
        step(1);

        // Mode 0, 8 bits, div 0, 0xA5
        en = 1'b1;
        step(2);
        edge_q.delete(); mosi_q.delete();
        start_xfer(32'hA5, 32'hA5, 18, 1'b1, t);
        wait_done(100);
        check(edge_q.size() == 16, "m0_edge_count", edge_q.size(), 16);
        if (edge_q.size() >= 16) begin
            check(edge_q[0] == t + 2, "m0_first_edge", edge_q[0], t + 2);
            check(edge_q[15] == t + 17, "m0_last_edge", edge_q[15], t + 17);
        end
        mb = 8'h0;
        foreach (mosi_q[i]) mb = {mb[6:0], mosi_q[i]};
        check(mb == 8'hA5 && mosi_q.size() == 8, "m0_mosi_seq", mb, 8'hA5);
        step(2);

        // Mode 3, LSB first, 32 bits, div 3
        cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; dtb = 2'b11; div = 8'd3;
        step(2);
        @(negedge clk);
        check(sck == 1'b1, "m3_idle_sck", sck, 1);
        step(1);
        edge_q.delete(); mosi_q.delete();
        start_xfer(32'h12345678, 32'h12345678, 261, 1'b1, t);
        wait_done(400);
        check(edge_q.size() == 64, "m3_edge_count", edge_q.size(), 64);
        if (edge_q.size() >= 2) begin
            check(edge_q[0] == t + 5, "m3_edge1", edge_q[0], t + 5);
            check(edge_q[1] == t + 9, "m3_edge2", edge_q[1], t + 9);
        end
        step(2);

        // Back-to-back with RX not consumed
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dtb = 2'b00; div = 8'd0; rx_ready = 1'b0;
        step(2);
        start_xfer(32'h3C, 32'h3C, 18, 1'b1, t);
        wait_done(100);
        step(1);
        tx_data = 32'hC3; tx_valid = 1'b1;
        rdy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_ready) rdy_seen++;
        end
        check(rdy_seen == 0, "b2b_stall", rdy_seen, 0);
        check(rx_data == 32'h3C, "b2b_rx_hold", rx_data, 32'h3C);
        check(rx_valid == 1'b1, "b2b_rx_valid_hold", rx_valid, 1);
        step(1);
        rx_ready = 1'b1;
        @(negedge clk);
        r = cyc;
        step(1);
        rx_ready = 1'b0;
        start_xfer(32'hC3, 32'hC3, 18, 1'b1, t2);
        check(t2 == r + 1, "b2b_resume_cycle", t2, r + 1);
        wait_done(100);
        step(1);
        rx_ready = 1'b1;
        step(2);

        // Abort at edge 5 of an 8-bit transfer
        div = 8'd1;
        step(2);
        edge_q.delete(); mosi_q.delete();
        dc = done_cnt;
        start_xfer(32'hF0, 32'h0, 0, 1'b0, t);
        for (int i = 0; i < 60 && edge_q.size() < 5; i++) begin
            @(negedge clk);
            #1;
        end
        en = 1'b0;
        @(negedge clk);
        check(nss_o == 4'hF, "abort_nss", nss_o, 4'hF);
        check({sck, busy, mosi} == 3'b0, "abort_sck_busy_mosi", {sck, busy, mosi}, 0);
        repeat (30) @(negedge clk);
        check(done_cnt == dc, "abort_no_done", done_cnt, dc);
        check(rx_valid == 1'b0, "abort_no_rx_valid", rx_valid, 0);

        // Slave select decoding
        step(1);
        en = 1'b1; ass = 1'b1; nss = 3'd2; div = 8'd0;
        step(3);
        @(negedge clk);
        check(nss_o == 4'hF, "ass1_idle", nss_o, 4'hF);
        step(1);
        start_xfer(32'h5A, 32'h5A, 18, 1'b1, t);
        @(negedge clk);
        check(nss_o == 4'b1011, "ass1_active", nss_o, 4'b1011);
        wait_done(100);
        check(nss_o == 4'hF, "ass1_release", nss_o, 4'hF);
        step(1);
        ass = 1'b0;
        repeat (2) @(negedge clk);
        check(nss_o == 4'b1011, "ass0_en", nss_o, 4'b1011);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check(nss_o == 4'hF, "ass0_dis", nss_o, 4'hF);
        step(1);
        en = 1'b1; ass = 1'b1; nss = 3'd5;
        step(2);
        start_xfer(32'h81, 32'h81, 18, 1'b1, t);
        @(negedge clk);
        check(nss_o == 4'hF, "nss_out_of_range", nss_o, 4'hF);
        wait_done(100);
        step(2);

        // Reset mid-transfer, then a clean transfer
        nss = 3'd0; dtb = 2'b11;
        step(1);
        start_xfer(32'hDEADBEEF, 32'h0, 0, 1'b0, t);
        repeat (10) @(negedge clk);
        check(busy == 1'b1, "pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check({sck, mosi, tx_ready, rx_valid, busy, done} == 6'b0, "midrst_ctl",
              {sck, mosi, tx_ready, rx_valid, busy, done}, 0);
        check(nss_o == 4'hF, "midrst_nss", nss_o, 4'hF);
        check(rx_data == 32'h0, "midrst_rx_data", rx_data, 0);
        step(1);
        rst = 1'b0;
        step(2);
        start_xfer(32'hCAFEF00D, 32'hCAFEF00D, 66, 1'b1, t);
        wait_done(200);
        step(5);

        check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
